// File: rtl/apb_gpio_flex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_gpio_flex_pkg
// Description : Shared constants for the APB GPIO controller: register byte
//               offsets and word indices, interrupt mode encoding, lock bits,
//               and the per-pin event match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_gpio_flex_pkg;

  // Register byte offsets (PADDR[6:0])
  localparam logic [6:0] c_OFF_DIR      = 7'h00;
  localparam logic [6:0] c_OFF_IN       = 7'h04;
  localparam logic [6:0] c_OFF_OUT      = 7'h08;
  localparam logic [6:0] c_OFF_INTEN    = 7'h0C;
  localparam logic [6:0] c_OFF_INTTYPE0 = 7'h10;
  localparam logic [6:0] c_OFF_INTTYPE1 = 7'h14;
  localparam logic [6:0] c_OFF_STATUS   = 7'h18;
  localparam logic [6:0] c_OFF_EN       = 7'h1C;
  localparam logic [6:0] c_OFF_DBEN     = 7'h20;
  localparam logic [6:0] c_OFF_DBCNT    = 7'h24;
  localparam logic [6:0] c_OFF_OUTSET   = 7'h28;
  localparam logic [6:0] c_OFF_OUTCLR   = 7'h2C;
  localparam logic [6:0] c_OFF_OUTTGL   = 7'h30;
  localparam logic [6:0] c_OFF_LOCK     = 7'h34;

  // Word indices as decoded from PADDR[6:2]
  localparam logic [4:0] c_IDX_DIR      = c_OFF_DIR[6:2];
  localparam logic [4:0] c_IDX_IN       = c_OFF_IN[6:2];
  localparam logic [4:0] c_IDX_OUT      = c_OFF_OUT[6:2];
  localparam logic [4:0] c_IDX_INTEN    = c_OFF_INTEN[6:2];
  localparam logic [4:0] c_IDX_INTTYPE0 = c_OFF_INTTYPE0[6:2];
  localparam logic [4:0] c_IDX_INTTYPE1 = c_OFF_INTTYPE1[6:2];
  localparam logic [4:0] c_IDX_STATUS   = c_OFF_STATUS[6:2];
  localparam logic [4:0] c_IDX_EN       = c_OFF_EN[6:2];
  localparam logic [4:0] c_IDX_DBEN     = c_OFF_DBEN[6:2];
  localparam logic [4:0] c_IDX_DBCNT    = c_OFF_DBCNT[6:2];
  localparam logic [4:0] c_IDX_OUTSET   = c_OFF_OUTSET[6:2];
  localparam logic [4:0] c_IDX_OUTCLR   = c_OFF_OUTCLR[6:2];
  localparam logic [4:0] c_IDX_OUTTGL   = c_OFF_OUTTGL[6:2];
  localparam logic [4:0] c_IDX_LOCK     = c_OFF_LOCK[6:2];

  // Interrupt mode encoding, two bits per pin in INTTYPE0/INTTYPE1
  typedef enum logic [1:0] {
    FALL     = 2'b00,
    RISE     = 2'b01,
    BOTH     = 2'b10,
    LEVEL_HI = 2'b11
  } inttype_e;

  // LOCK register bit positions
  localparam int c_LOCK_DIR = 0;  // guards DIR
  localparam int c_LOCK_OUT = 1;  // guards OUT, OUTSET, OUTCLR, OUTTGL
  localparam int c_LOCK_CFG = 2;  // guards INTEN, INTTYPE0/1, DBEN, DBCNT
  localparam int c_LOCK_W   = 3;

  // True when the filtered pin history matches the selected interrupt mode
  function automatic logic f_event_match(input logic [1:0] mode,
                                         input logic       filt,
                                         input logic       filt_d);
    logic match;
    match = 1'b0;
    case (inttype_e'(mode))
      FALL:     match = ~filt & filt_d;
      RISE:     match = filt & ~filt_d;
      BOTH:     match = filt ^ filt_d;
      LEVEL_HI: match = filt;
      default:  match = 1'b0;
    endcase
    return match;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_gpio_flex_pin_filter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pin_filter
// Description : One GPIO input lane: multi-flop synchroniser, debounce
//               counter, filtered value and its one-cycle-delayed copy used
//               as the edge reference. Everything freezes while i_en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_dben,
  input  logic [DEBOUNCE_W-1:0] i_dbcnt,
  input  logic                  i_raw,
  output logic                  o_sync,
  output logic                  o_filt,
  output logic                  o_filt_d
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic                   r_filt_d;
  logic [DEBOUNCE_W-1:0]  r_cnt;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchronise, debounce and keep the edge reference; hold when disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_cnt    <= '0;
    end else if (i_en) begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_filt_d <= r_filt;
      if (!i_dben) begin
        r_filt <= w_s;
        r_cnt  <= '0;
      end else if (w_s == r_filt) begin
        r_cnt  <= '0;
      end else if (r_cnt >= i_dbcnt) begin
        // >= so a threshold lowered mid-count takes effect at once
        r_filt <= w_s;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sync   = w_s;
  assign o_filt   = r_filt;
  assign o_filt_d = r_filt_d;

endmodule
`default_nettype wire

// File: rtl/apb_gpio_flex.sv
`default_nettype none
// ============================================================================
// Module      : apb_gpio_flex
// Description : APB GPIO controller top: register decode, sticky lock with
//               error response, output set/clear/toggle, W1C interrupt status
//               and registered level interrupt. Input lanes live in
//               gpio_pin_filter.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_gpio_flex
  import apb_gpio_flex_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_GPIO       = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_W     = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_in_sync,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic                      interrupt
);

  // Bits at and above NUM_GPIO are never stored
  localparam logic [31:0] c_PIN_MASK  = (NUM_GPIO >= 32) ? 32'hFFFF_FFFF :
                                        ((32'd1 << NUM_GPIO) - 32'd1);
  localparam logic [63:0] c_TYPE_MASK = (NUM_GPIO >= 32) ? {64{1'b1}} :
                                        ((64'd1 << (2 * NUM_GPIO)) - 64'd1);

  logic [31:0]           r_dir, r_out, r_inten, r_en, r_dben, r_status;
  logic [63:0]           r_inttype;
  logic [DEBOUNCE_W-1:0] r_dbcnt;
  logic [c_LOCK_W-1:0]   r_lock;
  logic                  r_irq;

  logic [NUM_GPIO-1:0]   w_sync, w_filt, w_filt_d, w_ev;
  logic [4:0]            w_idx;
  logic                  w_access, w_wr, w_mapped, w_reject, w_wr_ok;
  logic [31:0]           w_wdata, w_w1c, w_ev32;
  logic                  w_unused_paddr;

  assign w_idx    = PADDR[6:2];
  assign w_access = PSEL & PENABLE;
  assign w_wr     = w_access & PWRITE;
  assign w_mapped = (w_idx <= c_IDX_LOCK);
  assign w_wdata  = PWDATA & c_PIN_MASK;
  assign w_unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:7], PADDR[1:0]};

  // Writes refused by a lock bit, plus the read-only IN register
  always_comb begin
    w_reject = 1'b0;
    case (w_idx)
      c_IDX_IN:       w_reject = 1'b1;
      c_IDX_DIR:      w_reject = r_lock[c_LOCK_DIR];
      c_IDX_OUT,
      c_IDX_OUTSET,
      c_IDX_OUTCLR,
      c_IDX_OUTTGL:   w_reject = r_lock[c_LOCK_OUT];
      c_IDX_INTEN,
      c_IDX_INTTYPE0,
      c_IDX_INTTYPE1,
      c_IDX_DBEN,
      c_IDX_DBCNT:    w_reject = r_lock[c_LOCK_CFG];
      default:        w_reject = 1'b0;
    endcase
  end

  assign w_wr_ok = w_wr & w_mapped & ~w_reject;
  assign PSLVERR = w_access & (~w_mapped | (PWRITE & w_reject));
  assign PREADY  = 1'b1;

  // Read mux; write-only and unmapped words return 0
  always_comb begin
    PRDATA = '0;
    case (w_idx)
      c_IDX_DIR:      PRDATA = r_dir;
      c_IDX_IN:       PRDATA = 32'(w_filt);
      c_IDX_OUT:      PRDATA = r_out;
      c_IDX_INTEN:    PRDATA = r_inten;
      c_IDX_INTTYPE0: PRDATA = r_inttype[31:0];
      c_IDX_INTTYPE1: PRDATA = r_inttype[63:32];
      c_IDX_STATUS:   PRDATA = r_status;
      c_IDX_EN:       PRDATA = r_en;
      c_IDX_DBEN:     PRDATA = r_dben;
      c_IDX_DBCNT:    PRDATA = 32'(r_dbcnt);
      c_IDX_LOCK:     PRDATA = 32'(r_lock);
      default:        PRDATA = '0;
    endcase
  end

  // Configuration and output registers, updated on an accepted write
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dir     <= '0;
      r_out     <= '0;
      r_inten   <= '0;
      r_en      <= '0;
      r_dben    <= '0;
      r_inttype <= '0;
      r_dbcnt   <= '0;
      r_lock    <= '0;
    end else if (w_wr_ok) begin
      case (w_idx)
        c_IDX_DIR:      r_dir   <= w_wdata;
        c_IDX_OUT:      r_out   <= w_wdata;
        c_IDX_OUTSET:   r_out   <= r_out | w_wdata;
        c_IDX_OUTCLR:   r_out   <= r_out & ~w_wdata;
        c_IDX_OUTTGL:   r_out   <= r_out ^ w_wdata;
        c_IDX_INTEN:    r_inten <= w_wdata;
        c_IDX_INTTYPE0: r_inttype[31:0]  <= PWDATA & c_TYPE_MASK[31:0];
        c_IDX_INTTYPE1: r_inttype[63:32] <= PWDATA & c_TYPE_MASK[63:32];
        c_IDX_EN:       r_en    <= w_wdata;
        c_IDX_DBEN:     r_dben  <= w_wdata;
        c_IDX_DBCNT:    r_dbcnt <= PWDATA[DEBOUNCE_W-1:0];
        c_IDX_LOCK:     r_lock  <= r_lock | PWDATA[c_LOCK_W-1:0];
        default:        ;
      endcase
    end
  end

  // One filter lane and event detector per implemented pin
  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_filter (
      .clk      (HCLK),
      .rst      (HRESET),
      .i_en     (r_en[i]),
      .i_dben   (r_dben[i]),
      .i_dbcnt  (r_dbcnt),
      .i_raw    (gpio_in[i]),
      .o_sync   (w_sync[i]),
      .o_filt   (w_filt[i]),
      .o_filt_d (w_filt_d[i])
    );

    assign w_ev[i] = r_inten[i] & r_en[i] &
                     f_event_match(r_inttype[2*i +: 2], w_filt[i], w_filt_d[i]);
  end

  assign w_ev32 = 32'(w_ev);
  assign w_w1c  = (w_wr_ok && (w_idx == c_IDX_STATUS)) ? PWDATA : 32'd0;

  // Sticky status: a new event outranks a simultaneous clear
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_status <= '0;
    end else begin
      r_status <= ((r_status & ~w_w1c) | w_ev32) & c_PIN_MASK;
    end
  end

  // Level interrupt follows enabled status one cycle later
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_inten);
    end
  end

  assign interrupt    = r_irq;
  assign gpio_in_sync = w_sync;
  assign gpio_out     = r_out[NUM_GPIO-1:0];
  assign gpio_dir     = r_dir[NUM_GPIO-1:0];

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_flex.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_gpio_flex
// Description : Self-checking bench for apb_gpio_flex. A cycle-level
//               behavioural model of the register file and pin behaviour
//               predicts every output; directed scenarios add literal checks.
//               A second 8-pin instance exercises register width masking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_flex;

  localparam int NG = 20;
  localparam int SS = 2;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam bit [31:0] PMASK = (32'd1 << NG) - 32'd1;
  localparam bit [63:0] TMASK = (64'd1 << (2 * NG)) - 64'd1;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic [AW-1:0] PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic          PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [NG-1:0] gpio_in = '0;
  logic [NG-1:0] gpio_in_sync, gpio_out, gpio_dir;
  logic          interrupt;

  logic [31:0]   prdata8;
  logic          pready8, pslverr8, irq8;
  logic [7:0]    sync8, out8, dir8;

  always #5 HCLK = ~HCLK;

  apb_gpio_flex #(.APB_ADDR_WIDTH(AW), .NUM_GPIO(NG), .SYNC_STAGES(SS),
                  .DEBOUNCE_W(DW)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
    .gpio_in_sync(gpio_in_sync), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
    .interrupt(interrupt));

  apb_gpio_flex #(.APB_ADDR_WIDTH(AW), .NUM_GPIO(8), .SYNC_STAGES(3),
                  .DEBOUNCE_W(DW)) u_dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(prdata8),
    .PREADY(pready8), .PSLVERR(pslverr8), .gpio_in(gpio_in[7:0]),
    .gpio_in_sync(sync8), .gpio_out(out8), .gpio_dir(dir8),
    .interrupt(irq8));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit rnd_in = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0]   m_dir, m_out, m_inten, m_en, m_dben, m_status, m_f, m_fd;
  bit [63:0]   m_it;
  bit [DW-1:0] m_dbcnt;
  bit [2:0]    m_lock;
  bit          m_int;
  bit [SS-1:0] m_sh [NG];
  int          m_run [NG];

  always @(posedge HCLK) begin
    bit [31:0] ev, w1c, d;
    bit [63:0] tmp;
    bit        nxt_int, s;
    int        idx;
    if (HRESET) begin
      m_dir = 0; m_out = 0; m_inten = 0; m_en = 0; m_dben = 0; m_status = 0;
      m_f = 0; m_fd = 0; m_it = 0; m_dbcnt = 0; m_lock = 0; m_int = 0;
      for (int i = 0; i < NG; i++) begin m_sh[i] = 0; m_run[i] = 0; end
    end else begin
      ev = 0;
      for (int i = 0; i < NG; i++) begin
        if (m_inten[i] && m_en[i]) begin
          case (m_it[2*i +: 2])
            2'd0: ev[i] = m_fd[i] && !m_f[i];
            2'd1: ev[i] = m_f[i] && !m_fd[i];
            2'd2: ev[i] = m_f[i] != m_fd[i];
            default: ev[i] = m_f[i];
          endcase
        end
      end
      nxt_int = |(m_status & m_inten);
      // Pin path: the filter accepts a new level once it has been seen
      // (dbcnt+1) consecutive synchronised cycles
      for (int i = 0; i < NG; i++) begin
        if (m_en[i]) begin
          s = m_sh[i][SS-1];
          m_fd[i] = m_f[i];
          if (!m_dben[i] || s == m_f[i]) begin
            m_f[i] = s;
            m_run[i] = 0;
          end else if (m_run[i] >= int'(m_dbcnt)) begin
            m_f[i] = s;
            m_run[i] = 0;
          end else begin
            m_run[i]++;
          end
          m_sh[i] = {m_sh[i][SS-2:0], gpio_in[i]};
        end
      end
      w1c = 0;
      d = PWDATA;
      idx = int'(PADDR[6:2]);
      if (PSEL && PENABLE && PWRITE) begin
        case (idx)
          0:  if (!m_lock[0]) m_dir = d & PMASK;
          2:  if (!m_lock[1]) m_out = d & PMASK;
          3:  if (!m_lock[2]) m_inten = d & PMASK;
          4:  if (!m_lock[2]) begin tmp = m_it; tmp[31:0] = d; m_it = tmp & TMASK; end
          5:  if (!m_lock[2]) begin tmp = m_it; tmp[63:32] = d; m_it = tmp & TMASK; end
          6:  w1c = d;
          7:  m_en = d & PMASK;
          8:  if (!m_lock[2]) m_dben = d & PMASK;
          9:  if (!m_lock[2]) m_dbcnt = d[DW-1:0];
          10: if (!m_lock[1]) m_out = m_out | (d & PMASK);
          11: if (!m_lock[1]) m_out = m_out & ~d;
          12: if (!m_lock[1]) m_out = (m_out ^ d) & PMASK;
          13: m_lock = m_lock | d[2:0];
          default: ;
        endcase
      end
      m_status = ((m_status & ~w1c) | ev) & PMASK;
      m_int = nxt_int;
    end
  end

  function automatic bit [31:0] exp_rd(input int idx);
    case (idx)
      0: return m_dir;       1: return m_f;         2: return m_out;
      3: return m_inten;     4: return m_it[31:0];  5: return m_it[63:32];
      6: return m_status;    7: return m_en;        8: return m_dben;
      9: return {24'd0, m_dbcnt};
      13: return {29'd0, m_lock};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit exp_err();
    int idx;
    idx = int'(PADDR[6:2]);
    if (!(PSEL && PENABLE)) return 1'b0;
    if (idx > 13) return 1'b1;
    if (!PWRITE) return 1'b0;
    case (idx)
      1: return 1'b1;
      0: return m_lock[0];
      2, 10, 11, 12: return m_lock[1];
      3, 4, 5, 8, 9: return m_lock[2];
      default: return 1'b0;
    endcase
  endfunction

  // Compare every output against the model once per cycle
  always @(negedge HCLK) begin
    bit [31:0] es;
    if (chk_en) begin
      #2;
      es = 0;
      for (int i = 0; i < NG; i++) es[i] = m_sh[i][SS-1];
      chk("gpio_out", 32'(gpio_out), m_out);
      chk("gpio_dir", 32'(gpio_dir), m_dir);
      chk("gpio_in_sync", 32'(gpio_in_sync), es);
      chk("interrupt", 32'(interrupt), 32'(m_int));
      chk("PREADY", 32'(PREADY), 32'd1);
      chk("PRDATA", PRDATA, exp_rd(int'(PADDR[6:2])));
      chk("PSLVERR", 32'(PSLVERR), 32'(exp_err()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge HCLK);
    if (rnd_in)
      for (int i = 0; i < NG; i++)
        if ($urandom_range(0, 11) == 0) gpio_in[i] = ~gpio_in[i];
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    tick(); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = AW'(a); PWDATA = d;
    tick(); PENABLE = 1; #3; err = PSLVERR;
    tick(); PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic err, output logic [31:0] d8);
    tick(); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = AW'(a);
    tick(); PENABLE = 1; #3; d = PRDATA; err = PSLVERR; d8 = prdata8;
    tick(); PSEL = 0; PENABLE = 0;
  endtask

  task automatic rand_txn();
    int idx;
    logic [31:0] d;
    logic [AW-1:0] a;
    idx = $urandom_range(0, 15);
    if (idx == 13 && $urandom_range(0, 5) != 0) idx = 6;
    d = $urandom;
    if (idx == 9) d = $urandom_range(0, 6);
    a = AW'($urandom);
    a[6:2] = 5'(idx);
    tick(); PSEL = 1; PENABLE = 0; PWRITE = 1'($urandom_range(0, 1));
    PADDR = a; PWDATA = d;
    tick(); PENABLE = 1;
    tick(); PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = AW'($urandom);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    logic err;
    logic [31:0] d, d8;
    int exp;
    repeat (3) tick();
    HRESET = 0;
    chk_en = 1;

    // Reset state: every mapped word reads 0 without error
    for (int a = 0; a <= 'h34; a += 4) begin
      rd(32'(a), d, err, d8);
      chk("rst_rd", d, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end
    rd(32'h3C, d, err, d8);
    chk("unmapped_rd", d, 32'd0);
    chk("unmapped_err", 32'(err), 32'd1);
    chk("pready", 32'(PREADY), 32'd1);

    // Rising edge on pin 0, no debounce
    wr(32'h1C, 32'h1, err); wr(32'h20, 32'h0, err);
    wr(32'h0C, 32'h1, err); wr(32'h10, 32'h1, err);
    tick(); gpio_in[0] = 1'b1; PADDR = 'h004;
    for (int k = 1; k <= 5; k++) begin
      tick(); PADDR = (k <= 3) ? AW'('h004) : AW'('h018); #3;
      if (k <= 3) chk("in_latency", PRDATA, (k == 3) ? 32'd1 : 32'd0);
      if (k == 4) chk("status_set", PRDATA, 32'd1);
      chk("irq_latency", 32'(interrupt), (k == 5) ? 32'd1 : 32'd0);
    end
    wr(32'h18, 32'h1, err);
    tick(); #3;
    chk("irq_cleared", 32'(interrupt), 32'd0);
    rd(32'h18, d, err, d8);
    chk("status_w1c", d, 32'd0);

    // Debounce: short glitch rejected, long pulse accepted after 7 cycles
    tick(); gpio_in[0] = 1'b0;
    repeat (5) tick();
    wr(32'h20, 32'h1, err); wr(32'h24, 32'h4, err); wr(32'h18, 32'hFFFF_FFFF, err);
    tick(); gpio_in[0] = 1'b1; PADDR = 'h004;
    for (int k = 1; k <= 14; k++) begin
      tick(); if (k == 3) gpio_in[0] = 1'b0; #3;
      chk("glitch_in", PRDATA, 32'd0);
    end
    rd(32'h18, d, err, d8);
    chk("glitch_status", d, 32'd0);
    tick(); gpio_in[0] = 1'b1; PADDR = 'h004;
    for (int k = 1; k <= 20; k++) begin
      tick(); if (k == 10) gpio_in[0] = 1'b0; #3;
      exp = (k >= 7 && k < 17) ? 1 : 0;
      chk("db_in", PRDATA, 32'(exp));
    end
    rd(32'h18, d, err, d8);
    chk("db_status", d, 32'd1);
    wr(32'h18, 32'h1, err);

    // Level-high mode: set wins over a simultaneous clear
    wr(32'h10, 32'h3, err);
    tick(); gpio_in[0] = 1'b1;
    repeat (10) tick();
    wr(32'h18, 32'h1, err);
    rd(32'h18, d, err, d8);
    chk("level_setwins", d, 32'd1);
    tick(); gpio_in[0] = 1'b0;
    repeat (10) tick();
    wr(32'h18, 32'h1, err);
    rd(32'h18, d, err, d8);
    chk("level_clear", d, 32'd0);

    // Output operations and lock
    wr(32'h08, 32'hF0, err); wr(32'h28, 32'h01, err);
    wr(32'h2C, 32'h10, err); wr(32'h30, 32'h03, err);
    chk("out_ops", 32'(gpio_out), 32'hE2);
    wr(32'h34, 32'h2, err);
    wr(32'h08, 32'h0, err);
    chk("lock_err", 32'(err), 32'd1);
    chk("lock_hold", 32'(gpio_out), 32'hE2);
    wr(32'h04, 32'h5, err);
    chk("in_wr_err", 32'(err), 32'd1);
    wr(32'h34, 32'h0, err);
    rd(32'h34, d, err, d8);
    chk("lock_sticky", d, 32'd2);
    rd(32'h30, d, err, d8);
    chk("outtgl_rd", d, 32'd0);

    // Width masking on both builds
    wr(32'h00, 32'hFFFF_FFFF, err);
    rd(32'h00, d, err, d8);
    chk("dir_mask20", d, 32'h000F_FFFF);
    chk("dir_mask8", d8, 32'h0000_00FF);
    chk("gpio_dir8", 32'(dir8), 32'hFF);

    // Randomised traffic with periodic resets
    tick(); HRESET = 1; tick(); tick(); HRESET = 0;
    rnd_in = 1;
    for (int t = 0; t < 2500; t++) begin
      if (t % 500 == 250) begin
        tick(); HRESET = 1; tick(); tick(); HRESET = 0;
      end
      rand_txn();
    end
    rnd_in = 0;
    repeat (3) tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL timeout: run did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_gpio_flex.md
Name: apb_gpio_flex

Overview:
- Parametrised next-generation APB GPIO controller: NUM_GPIO pins, configurable synchroniser depth, per-pin debounce filter, four interrupt modes including level-high, write-1-to-clear status, sticky lock with error response.
- Sits on the peripheral APB bus beside the existing GPIO block.
- Drives pad out/dir and a single level interrupt line to the event unit.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; PADDR[6:2] selects register
NUM_GPIO, 32, pin count, legal 1..32; register bits at and above NUM_GPIO read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser flops, legal 2..4
DEBOUNCE_W, 8, width of debounce threshold and per-pin counter

Ports:
HCLK  in  1  clock
HRESET  in  1  reset, synchronous, active-high
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  32  write data
PWRITE  in  1  write strobe
PSEL  in  1  select
PENABLE  in  1  access phase
PRDATA  out  32  read data, combinational on PADDR[6:2]
PREADY  out  1  tied 1
PSLVERR  out  1  error response
gpio_in  in  NUM_GPIO  raw pad inputs
gpio_in_sync  out  NUM_GPIO  last synchroniser stage
gpio_out  out  NUM_GPIO  OUT register
gpio_dir  out  NUM_GPIO  DIR register, 1 = output
interrupt  out  1  registered level interrupt

Behaviour:
- Clock and reset: one clock HCLK; reset HRESET is synchronous and active-high. All registers, counters and outputs reset to 0, except PREADY=1.
- Register map (byte offset), all 32-bit:
  - 0x00 DIR
  - 0x04 IN (RO, filtered value)
  - 0x08 OUT
  - 0x0C INTEN
  - 0x10 INTTYPE0 (2 bits per pin, pins 0-15)
  - 0x14 INTTYPE1 (pins 16-31)
  - 0x18 STATUS (W1C)
  - 0x1C EN
  - 0x20 DBEN
  - 0x24 DBCNT [DEBOUNCE_W-1:0]
  - 0x28 OUTSET
  - 0x2C OUTCLR
  - 0x30 OUTTGL (WO, read 0)
  - 0x34 LOCK
  - Unmapped addresses read 0.
- Write timing: a write takes effect on the HCLK edge where PSEL&PENABLE&PWRITE are all high.
- LOCK: bits are set-only; cleared only by HRESET.
  - LOCK[0] blocks DIR.
  - LOCK[1] blocks OUT/OUTSET/OUTCLR/OUTTGL.
  - LOCK[2] blocks INTEN/INTTYPE0/INTTYPE1/DBEN/DBCNT.
  - A blocked write leaves the register unchanged. Blocked writes still read normally.
- PSLVERR: asserted combinationally during the access phase for a blocked write, a write to IN, or any access to an unmapped address. Otherwise 0.
- Input path, per pin i with EN[i]=1:
  - SYNC_STAGES-flop synchroniser s[i].
  - Filter register f[i] with counter c[i].
  - DBEN[i]=0: f<=s, c<=0.
  - DBEN[i]=1, s==f: c<=0.
  - DBEN[i]=1, s!=f and c>=DBCNT: f<=s, c<=0.
  - DBEN[i]=1, otherwise: c<=c+1.
  - Latency from a gpio_in change to IN: SYNC_STAGES+1 cycles, plus DBCNT when debounced.
  - A glitch shorter than DBCNT+1 synchronised cycles never reaches f.
  - A DBCNT change mid-count applies immediately (>= compare).
- EN[i]=0: s, f, c and f_d for pin i hold their values; no events are generated for that pin.
- Edge reference: f_d <= f every cycle.
- Interrupt mode per pin, from INTTYPE bits {2i+1,2i}:
  - 00 falling edge
  - 01 rising edge
  - 10 either edge
  - 11 level-high (event every cycle while f=1)
- Events: ev[i] = INTEN[i] & EN[i] & mode match.
- STATUS: STATUS <= (STATUS & ~w1c) | ev, where w1c = PWDATA on a STATUS write, else 0. If an event and a clear hit the same bit in the same cycle, the set wins.
- interrupt <= |(STATUS & INTEN), i.e. one cycle after STATUS updates.
- OUT ops: OUTSET sets, OUTCLR clears, OUTTGL XORs OUT with PWDATA.
- Reset mid-operation: counters and STATUS cleared; the filter restarts from 0, so a high input produces a rising event after the reset-path latency.

Decomposition:
- Package apb_gpio_flex_pkg:
  - register offset localparams
  - inttype encoding constants (FALL, RISE, BOTH, LEVEL_HI)
  - lock bit indices
- Sub-module gpio_pin_filter (parameters SYNC_STAGES, DEBOUNCE_W; per-pin synchroniser, debounce counter, f and f_d), instantiated NUM_GPIO times in a generate loop.
- Top level contains the APB decode, lock logic, STATUS and interrupt.

Test Plan:
- Reset, then read all offsets -> all 0; PREADY=1; PSLVERR=0 on mapped reads; read 0x3C -> PRDATA=0, PSLVERR=1.
- EN=0x1, DBEN=0, INTEN=0x1, INTTYPE0=0x1; drive gpio_in[0] 0->1 -> IN[0]=1 after 3 cycles, STATUS=0x1 next cycle, interrupt=1 one cycle later. Write STATUS=0x1 -> interrupt=0 within 2 cycles.
- DBEN=0x1, DBCNT=4: 3-cycle pulse on pin 0 -> IN stays 0, STATUS stays 0; 10-cycle pulse -> IN[0]=1 exactly SYNC_STAGES+1+4 cycles after the edge.
- Level mode INTTYPE0=0x3, pin 0 held high: write STATUS=0x1 -> bit remains 1 (set wins); release pin, then W1C -> STATUS=0.
- OUT=0xF0, OUTSET=0x01, OUTCLR=0x10, OUTTGL=0x03 -> gpio_out=0xE2. Then LOCK=0x2, write OUT=0 -> PSLVERR=1, gpio_out stays 0xE2. Write LOCK=0 -> LOCK still 0x2.
- NUM_GPIO=8 build: write DIR=0xFFFFFFFF -> read 0x000000FF; gpio_dir=0xFF.
